// File: rtl/rx_bit_unstuff_pkg.sv
// Shared USB receive/transmit constants: FSM encoding, SYNC pattern, stuffing defaults.
// Imported by the bit unstuffer and its ones counter.
package rx_bit_unstuff_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SYNC_HUNT = 2'd1;
    localparam logic [1:0] ST_RECEIVE   = 2'd2;
    localparam logic [1:0] ST_ERROR     = 2'd3;

    // bit 0 is the first-received bit: seven 0s followed by a 1
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    localparam int STUFF_LIMIT_DEF  = 6;
    localparam int SYNC_TIMEOUT_DEF = 16;

    function automatic logic pid_ok(input logic [7:0] b);
        return b[3:0] == ~b[7:4];
    endfunction

endpackage

// File: rtl/rx_stuff_counter.sv
// Consecutive-ones counter with stuff-position detect; shared with the transmit bit-stuffer.
// Flags are combinational from the current count and bit; the count updates on gclk.
// No backpressure: one bit per qualified cycle.
module rx_stuff_counter
    import rx_bit_unstuff_pkg::*;
#(
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
    input  logic gclk,
    input  logic reset_l,
    input  logic bit_vld,
    input  logic bit_in,
    input  logic load_one,
    output logic stuff_drop,
    output logic stuff_viol
);

    localparam int CW = $clog2(STUFF_LIMIT + 1);

    logic [CW-1:0] ones_q, ones_d;
    logic          stuff_pos;

    assign stuff_pos  = (ones_q == CW'(STUFF_LIMIT));
    assign stuff_drop = bit_vld & stuff_pos & ~bit_in;
    assign stuff_viol = bit_vld & stuff_pos &  bit_in;

    always_comb begin
        ones_d = ones_q;
        if (load_one) begin
            ones_d = CW'(1);
        end else if (bit_vld) begin
            if (stuff_pos || !bit_in)
                ones_d = '0;
            else
                ones_d = ones_q + CW'(1);
        end
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l)
            ones_q <= '0;
        else
            ones_q <= ones_d;
    end

endmodule

// File: rtl/rx_bit_unstuff.sv
// USB RX bit unstuffer: SYNC hunt, stuffed-zero removal, LSB-first byte assembly.
// All outputs registered; byte strobe one cycle after its 8th data bit. Optional PID check: RX_PID_CHECK_EN.
// No backpressure: consumes one bit per gclk while rx_data_valid is high.
module rx_bit_unstuff
    import rx_bit_unstuff_pkg::*;
#(
    parameter int SYNC_TIMEOUT = SYNC_TIMEOUT_DEF,
    parameter int STUFF_LIMIT  = STUFF_LIMIT_DEF
) (
    input  logic       gclk,
    input  logic       reset_l,
    input  logic       rx_data_in,
    input  logic       rx_data_valid,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       stuff_err,
    output logic       sync_err,
`ifdef RX_PID_CHECK_EN
    output logic [3:0] rx_pid,
    output logic       pid_err,
`endif
    output logic       align_err
);

    localparam int HW = $clog2(SYNC_TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [6:0]    sync_hist_q, sync_hist_d;
    logic [HW-1:0] hunt_q, hunt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          byte_vld_q, byte_vld_d;
    logic          active_q, active_d;
    logic          eop_q, eop_d;
    logic          stuff_err_q, stuff_err_d;
    logic          sync_err_q, sync_err_d;
    logic          align_err_q, align_err_d;

    logic [7:0]    sync_win;
    logic [7:0]    byte_next;
    logic [HW-1:0] hunt_inc;
    logic          sync_hit;
    logic          rcv_bit;
    logic          stuff_drop, stuff_viol;

    assign rcv_bit  = (state_q == ST_RECEIVE) && rx_data_valid;
    assign sync_win = {rx_data_in, sync_hist_q};
    assign hunt_inc = hunt_q + HW'(1);

    rx_stuff_counter #(.STUFF_LIMIT(STUFF_LIMIT)) u_stuff (
        .gclk       (gclk),
        .reset_l    (reset_l),
        .bit_vld    (rcv_bit),
        .bit_in     (rx_data_in),
        .load_one   (sync_hit),
        .stuff_drop (stuff_drop),
        .stuff_viol (stuff_viol)
    );

    always_comb begin
        state_d     = state_q;
        sync_hist_d = sync_hist_q;
        hunt_d      = hunt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        byte_vld_d  = 1'b0;
        eop_d       = 1'b0;
        stuff_err_d = 1'b0;
        sync_err_d  = 1'b0;
        align_err_d = 1'b0;
        sync_hit    = 1'b0;
        byte_next   = shift_q;
        byte_next[bit_cnt_q] = rx_data_in;

        case (state_q)
            ST_IDLE: begin
                if (rx_data_valid) begin
                    // pre-fill history with idle 1s so SYNC needs 8 real bits
                    sync_hist_d = {rx_data_in, 6'h3F};
                    hunt_d      = HW'(1);
                    state_d     = ST_SYNC_HUNT;
                end
            end
            ST_SYNC_HUNT: begin
                if (!rx_data_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    sync_hist_d = sync_win[7:1];
                    hunt_d      = hunt_inc;
                    if (sync_win == SYNC_PATTERN) begin
                        sync_hit  = 1'b1;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_RECEIVE;
                    end else if (hunt_inc == HW'(SYNC_TIMEOUT)) begin
                        sync_err_d = 1'b1;
                        state_d    = ST_ERROR;
                    end
                end
            end
            ST_RECEIVE: begin
                if (!rx_data_valid) begin
                    eop_d       = 1'b1;
                    align_err_d = (bit_cnt_q != 3'd0);
                    state_d     = ST_IDLE;
                end else if (stuff_viol) begin
                    stuff_err_d = 1'b1;
                    state_d     = ST_ERROR;
                end else if (!stuff_drop) begin
                    shift_d   = byte_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_d  = byte_next;
                        byte_vld_d = 1'b1;
                    end
                end
            end
            default: begin
                if (!rx_data_valid)
                    state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d == ST_RECEIVE);
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            sync_hist_q <= '0;
            hunt_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            byte_vld_q  <= 1'b0;
            active_q    <= 1'b0;
            eop_q       <= 1'b0;
            stuff_err_q <= 1'b0;
            sync_err_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_hist_q <= sync_hist_d;
            hunt_q      <= hunt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            byte_vld_q  <= byte_vld_d;
            active_q    <= active_d;
            eop_q       <= eop_d;
            stuff_err_q <= stuff_err_d;
            sync_err_q  <= sync_err_d;
            align_err_q <= align_err_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = byte_vld_q;
    assign rx_active     = active_q;
    assign rx_eop        = eop_q;
    assign stuff_err     = stuff_err_q;
    assign sync_err      = sync_err_q;
    assign align_err     = align_err_q;

`ifdef RX_PID_CHECK_EN
    logic       first_q, first_d;
    logic [3:0] rx_pid_q, rx_pid_d;
    logic       pid_err_q, pid_err_d;

    always_comb begin
        first_d   = first_q;
        rx_pid_d  = rx_pid_q;
        pid_err_d = 1'b0;
        if (sync_hit)
            first_d = 1'b1;
        else if (byte_vld_d) begin
            first_d = 1'b0;
            if (first_q) begin
                if (pid_ok(rx_byte_d))
                    rx_pid_d = rx_byte_d[3:0];
                else
                    pid_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            first_q   <= 1'b0;
            rx_pid_q  <= '0;
            pid_err_q <= 1'b0;
        end else begin
            first_q   <= first_d;
            rx_pid_q  <= rx_pid_d;
            pid_err_q <= pid_err_d;
        end
    end

    assign rx_pid  = rx_pid_q;
    assign pid_err = pid_err_q;
`endif

endmodule

// File: tb/tb_rx_bit_unstuff.sv
// Randomized + directed bench for rx_bit_unstuff against a per-packet reference model.
module tb_rx_bit_unstuff;

    localparam int SYNC_TIMEOUT = 16;
    localparam int STUFF_LIMIT  = 6;
    localparam int MAXC         = 512;

    logic       gclk = 1'b0;
    logic       reset_l;
    logic       rx_data_in;
    logic       rx_data_valid;
    logic [7:0] rx_byte;
    logic       rx_byte_valid, rx_active, rx_eop, stuff_err, sync_err, align_err;
`ifdef RX_PID_CHECK_EN
    logic [3:0] rx_pid;
    logic       pid_err;
`endif

    rx_bit_unstuff dut (
        .gclk          (gclk),
        .reset_l       (reset_l),
        .rx_data_in    (rx_data_in),
        .rx_data_valid (rx_data_valid),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_active     (rx_active),
        .rx_eop        (rx_eop),
        .stuff_err     (stuff_err),
        .sync_err      (sync_err),
`ifdef RX_PID_CHECK_EN
        .rx_pid        (rx_pid),
        .pid_err       (pid_err),
`endif
        .align_err     (align_err)
    );

    always #5 gclk = ~gclk;

    int total = 0;
    int bad   = 0;

    bit          pkt[$];
    logic [31:0] obsv[$];
    int          tx_ones;
    logic [7:0]  m_byte;
    logic [3:0]  m_pid;

    bit         e_act[MAXC], e_bv[MAXC], e_eop[MAXC], e_se[MAXC], e_sy[MAXC], e_al[MAXC], e_pe[MAXC];
    bit         e_pld[MAXC];
    logic [7:0] s_byte[MAXC], e_byte[MAXC];
    logic [3:0] e_pid[MAXC];

    function automatic logic [31:0] obs_now();
        logic [31:0] v = '0;
        v[0] = rx_active; v[1] = rx_byte_valid; v[9:2] = rx_byte;
        v[10] = rx_eop; v[11] = stuff_err; v[12] = sync_err; v[13] = align_err;
`ifdef RX_PID_CHECK_EN
        v[17:14] = rx_pid; v[18] = pid_err;
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_vec(int k);
        logic [31:0] v = '0;
        v[0] = e_act[k]; v[1] = e_bv[k]; v[9:2] = e_byte[k];
        v[10] = e_eop[k]; v[11] = e_se[k]; v[12] = e_sy[k]; v[13] = e_al[k];
`ifdef RX_PID_CHECK_EN
        v[17:14] = e_pid[k]; v[18] = e_pe[k];
`endif
        return v;
    endfunction

    // Transmitter-side helpers: push_bit inserts a 0 after six 1s, push_raw does not.
    task automatic push_bit(bit b);
        pkt.push_back(b);
        tx_ones = b ? tx_ones + 1 : 0;
        if (tx_ones == STUFF_LIMIT) begin
            pkt.push_back(1'b0);
            tx_ones = 0;
        end
    endtask

    task automatic push_byte(logic [7:0] b);
        for (int j = 0; j < 8; j++) push_bit(b[j]);
    endtask

    task automatic push_sync();
        for (int j = 0; j < 7; j++) pkt.push_back(1'b0);
        pkt.push_back(1'b1);
        tx_ones = 1;
    endtask

    // Reference: scan the whole packet for SYNC, then apply the stuffing rules bit by bit.
    task automatic build_expect();
        int n = pkt.size();
        int sync_at = -1;
        int ones = 0;
        bit err = 0;
        bit first = 1;
        bit data[$];
        logic [7:0] cb, cur_b;
        logic [3:0] cur_p;
        for (int k = 0; k < n + 3; k++) begin
            e_act[k] = 0; e_bv[k] = 0; e_eop[k] = 0; e_se[k] = 0; e_sy[k] = 0;
            e_al[k] = 0; e_pe[k] = 0; e_pld[k] = 0; s_byte[k] = 8'h00;
        end
        for (int i = 0; i < n; i++) begin
            if (i >= 7) begin
                bit m = pkt[i];
                for (int j = 0; j < 7; j++) if (pkt[i-7+j] != 1'b0) m = 0;
                if (m) begin sync_at = i; break; end
            end
            if (i + 1 == SYNC_TIMEOUT) begin e_sy[i] = 1; err = 1; break; end
        end
        if (sync_at >= 0) begin
            ones = 1;
            e_act[sync_at] = 1;
            for (int i = sync_at + 1; i < n && !err; i++) begin
                if (ones == STUFF_LIMIT) begin
                    if (pkt[i]) begin e_se[i] = 1; err = 1; end
                    else ones = 0;
                end else begin
                    data.push_back(pkt[i]);
                    ones = pkt[i] ? ones + 1 : 0;
                    if (data.size() % 8 == 0) begin
                        cb = 8'h00;
                        for (int j = 0; j < 8; j++) cb[j] = data[data.size() - 8 + j];
                        e_bv[i] = 1; s_byte[i] = cb;
                        if (first) begin
                            if (cb[3:0] == ~cb[7:4]) e_pld[i] = 1;
                            else e_pe[i] = 1;
                        end
                        first = 0;
                    end
                end
                if (!err) e_act[i] = 1;
            end
            if (!err) begin
                e_eop[n] = 1;
                e_al[n]  = (data.size() % 8) != 0;
            end
        end
        cur_b = m_byte; cur_p = m_pid;
        for (int k = 0; k < n + 3; k++) begin
            if (e_bv[k]) cur_b = s_byte[k];
            if (e_pld[k]) cur_p = s_byte[k][3:0];
            e_byte[k] = cur_b; e_pid[k] = cur_p;
        end
        m_byte = cur_b; m_pid = cur_p;
    endtask

    task automatic run_pkt();
        int n = pkt.size();
        build_expect();
        obsv.delete();
        for (int k = 0; k < n + 3; k++) begin
            rx_data_valid = (k < n);
            rx_data_in    = (k < n) ? pkt[k] : 1'b1;
            @(posedge gclk); #1;
            obsv.push_back(obs_now());
        end
        rx_data_valid = 1'b0; rx_data_in = 1'b1;
    endtask

    function automatic int count_bit(int b);
        int c = 0;
        foreach (obsv[k]) c += obsv[k][b];
        return c;
    endfunction

    task automatic test_reset();
        reset_l = 1'b0; rx_data_valid = 1'b0; rx_data_in = 1'b1;
        m_byte = 8'h00; m_pid = 4'h0;
        repeat (3) @(posedge gclk);
        #1;
        total++;
        if (obs_now() !== 32'h0) begin bad++; $display("FAIL reset_in got=%h exp=0", obs_now()); end
        reset_l = 1'b1;
        @(posedge gclk); #1;
        total++;
        if (obs_now() !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", obs_now()); end
    endtask

    task automatic test_byte_a5();
        pkt.delete(); push_sync(); push_byte(8'hA5);
        run_pkt();
        foreach (obsv[k]) begin
            total++;
            if (obsv[k] !== exp_vec(k)) begin bad++; $display("FAIL a5 cyc=%0d got=%h exp=%h", k, obsv[k], exp_vec(k)); end
        end
        total++;
        if (obsv[15][1] !== 1'b1 || obsv[15][9:2] !== 8'hA5) begin
            bad++; $display("FAIL a5_strobe got=%h exp byte a5 strobed at cycle 15", obsv[15]);
        end
        total++;
        if (obsv[16][10] !== 1'b1 || obsv[16][13] !== 1'b0) begin
            bad++; $display("FAIL a5_eop got=%h exp eop=1 align=0", obsv[16]);
        end
    endtask

    task automatic test_stuffed_ff();
        pkt.delete(); push_sync(); push_byte(8'hFF);
        total++;
        if (pkt.size() !== 17) begin bad++; $display("FAIL ff_len got=%0d exp=17", pkt.size()); end
        run_pkt();
        foreach (obsv[k]) begin
            total++;
            if (obsv[k] !== exp_vec(k)) begin bad++; $display("FAIL ff cyc=%0d got=%h exp=%h", k, obsv[k], exp_vec(k)); end
        end
        total++;
        if (rx_byte !== 8'hFF || count_bit(1) != 1 || count_bit(11) != 0) begin
            bad++; $display("FAIL ff_byte got=%h strobes=%0d serr=%0d exp ff/1/0", rx_byte, count_bit(1), count_bit(11));
        end
    endtask

    task automatic test_stuff_violation();
        pkt.delete(); push_sync();
        for (int j = 0; j < 6; j++) pkt.push_back(1'b1);
        for (int j = 0; j < 10; j++) pkt.push_back(1'($urandom_range(0, 1)));
        run_pkt();
        foreach (obsv[k]) begin
            total++;
            if (obsv[k] !== exp_vec(k)) begin bad++; $display("FAIL stuffv cyc=%0d got=%h exp=%h", k, obsv[k], exp_vec(k)); end
        end
        total++;
        if (count_bit(11) != 1 || count_bit(1) != 0 || count_bit(10) != 0 || obsv[13][0] !== 1'b0) begin
            bad++; $display("FAIL stuffv_pulses serr=%0d bv=%0d eop=%0d exp 1/0/0", count_bit(11), count_bit(1), count_bit(10));
        end
    endtask

    task automatic test_sync_timeout();
        pkt.delete();
        for (int j = 0; j < 16; j++) pkt.push_back(1'b1);
        run_pkt();
        foreach (obsv[k]) begin
            total++;
            if (obsv[k] !== exp_vec(k)) begin bad++; $display("FAIL synct cyc=%0d got=%h exp=%h", k, obsv[k], exp_vec(k)); end
        end
        total++;
        if (obsv[15][12] !== 1'b1 || count_bit(12) != 1) begin
            bad++; $display("FAIL synct_pulse got=%h cnt=%0d exp pulse at cycle 15 only", obsv[15], count_bit(12));
        end
        pkt.delete(); push_sync(); push_byte(8'h5A);
        run_pkt();
        foreach (obsv[k]) begin
            total++;
            if (obsv[k] !== exp_vec(k)) begin bad++; $display("FAIL synct_clean cyc=%0d got=%h exp=%h", k, obsv[k], exp_vec(k)); end
        end
        total++;
        if (rx_byte !== 8'h5A) begin bad++; $display("FAIL synct_byte got=%h exp=5a", rx_byte); end
    endtask

    task automatic test_align();
        pkt.delete(); push_sync(); push_byte(8'h3C);
        push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
        run_pkt();
        foreach (obsv[k]) begin
            total++;
            if (obsv[k] !== exp_vec(k)) begin bad++; $display("FAIL align cyc=%0d got=%h exp=%h", k, obsv[k], exp_vec(k)); end
        end
        total++;
        if (obsv[19][10] !== 1'b1 || obsv[19][13] !== 1'b1 || rx_byte !== 8'h3C) begin
            bad++; $display("FAIL align_eop got=%h byte=%h exp eop+align, byte 3c", obsv[19], rx_byte);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 40; p++) begin
            pkt.delete();
            for (int j = 0; j < int'($urandom_range(0, 5)); j++) pkt.push_back(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) != 0) push_sync();
            for (int j = 0; j < int'($urandom_range(1, 4)); j++)
                push_byte(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            if ($urandom_range(0, 2) == 0)
                for (int j = 0; j < int'($urandom_range(0, 12)); j++) pkt.push_back(1'($urandom_range(0, 1)));
            run_pkt();
            foreach (obsv[k]) begin
                total++;
                if (obsv[k] !== exp_vec(k)) begin bad++; $display("FAIL rand p=%0d cyc=%0d got=%h exp=%h", p, k, obsv[k], exp_vec(k)); end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        pkt.delete(); push_sync();
        for (int j = 0; j < 4; j++) pkt.push_back(1'(j & 1));
        foreach (pkt[k]) begin
            rx_data_valid = 1'b1; rx_data_in = pkt[k];
            @(posedge gclk); #1;
        end
        reset_l = 1'b0;
        #1;
        total++;
        if (obs_now() !== 32'h0) begin bad++; $display("FAIL midrst_async got=%h exp=0", obs_now()); end
        @(posedge gclk); #1;
        rx_data_valid = 1'b0; rx_data_in = 1'b1;
        @(posedge gclk); #1;
        reset_l = 1'b1;
        m_byte = 8'h00; m_pid = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge gclk); #1;
            total++;
            if (obs_now() !== 32'h0) begin bad++; $display("FAIL midrst_after cyc=%0d got=%h exp=0", k, obs_now()); end
        end
    endtask

`ifdef RX_PID_CHECK_EN
    task automatic test_pid();
        pkt.delete(); push_sync(); push_byte(8'hE1); push_byte(8'h00);
        run_pkt();
        foreach (obsv[k]) begin
            total++;
            if (obsv[k] !== exp_vec(k)) begin bad++; $display("FAIL pid_e1 cyc=%0d got=%h exp=%h", k, obsv[k], exp_vec(k)); end
        end
        total++;
        if (rx_pid !== 4'h1 || count_bit(18) != 0) begin
            bad++; $display("FAIL pid_e1_val got=%h perr=%0d exp 1/0", rx_pid, count_bit(18));
        end
        pkt.delete(); push_sync(); push_byte(8'hE2); push_byte(8'hE2);
        run_pkt();
        foreach (obsv[k]) begin
            total++;
            if (obsv[k] !== exp_vec(k)) begin bad++; $display("FAIL pid_e2 cyc=%0d got=%h exp=%h", k, obsv[k], exp_vec(k)); end
        end
        total++;
        if (count_bit(18) != 1 || rx_pid !== 4'h1 || count_bit(1) != 2) begin
            bad++; $display("FAIL pid_e2_err perr=%0d pid=%h bv=%0d exp 1/1/2", count_bit(18), rx_pid, count_bit(1));
        end
    endtask
`endif

    initial begin
        tx_ones = 0;
        test_reset();
        test_byte_a5();
        test_stuffed_ff();
        test_stuff_violation();
        test_sync_timeout();
        test_align();
        test_random();
        test_reset_mid_packet();
`ifdef RX_PID_CHECK_EN
        test_pid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
